// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-and-add multiplier: one W-bit ripple adder, FSM IDLE -> ADD (W cycles) -> DONE.
// P updates only on entry to DONE; Start outside IDLE is ignored.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module seq_mult_ctrl #(
  parameter int W = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic [2*W-1:0]   P,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic [W:0]     carry;
  logic [2*W-1:0] shifted;

  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_ripple
      full_adder u_fa (
        .a_i   (acc_q[gi]),
        .b_i   (addend[gi]),
        .cin_i (carry[gi]),
        .s_o   (sum[gi]),
        .cout_o(carry[gi+1])
      );
    end
  endgenerate

  // Carry-out becomes the new ACC MSB, so the W+1-bit partial sum is never truncated.
  assign shifted = {carry[W], sum, q_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        acc_d = shifted[2*W-1:W];
        q_d   = shifted[W-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          p_d     = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign Busy = (state_q == ST_ADD);
  assign Done = (state_q == ST_DONE);
endmodule
